gradient_stream: RTL and testbench

//  Streaming, parametrised successor to the fixed 6x6 Sobel gradient stage of the Harris corner pipeline.

---
 rtl/gradient_stream_if.sv | 38 +++
 rtl/gradient_stream.sv | 166 ++++++++++++++++
 tb/tb_gradient_stream.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gradient_stream_if.sv
// gradient_stream_if
//   Handshake/bus bundle for gradient_stream.
//   master : upstream window source plus downstream sink (drives in_*, out_ready)
//   slave  : the gradient stage itself (drives in_ready, out_*)
//   Signals:
//     in_valid / in_ready      window beat handshake
//     in_mode                  kernel select travelling with the beat
//     in_window                WIN*WIN pixels, pixel (r,c) at [(r*WIN+c)*PIX_W +: PIX_W]
//     out_valid / out_ready    gradient beat handshake
//     out_gx / out_gy          N*N signed gradients, element (r,c) at [(r*N+c)*OUT_W +: OUT_W]
//     out_sat                  some element of the beat was clamped
interface gradient_stream_if #(
    parameter int WIN   = 6,
    parameter int PIX_W = 8,
    parameter int OUT_W = 16
);
    localparam int N = WIN - 2;

    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               in_mode;
    logic [WIN*WIN*PIX_W-1:0] in_window;
    logic                     out_valid;
    logic                     out_ready;
    logic [N*N*OUT_W-1:0]     out_gx;
    logic [N*N*OUT_W-1:0]     out_gy;
    logic                     out_sat;

    modport master (
        output in_valid, in_mode, in_window, out_ready,
        input  in_ready, out_valid, out_gx, out_gy, out_sat
    );

    modport slave (
        input  in_valid, in_mode, in_window, out_ready,
        output in_ready, out_valid, out_gx, out_gy, out_sat
    );
endinterface

// File: rtl/gradient_stream.sv
// gradient_stream
//   Two-stage streaming gradient stage. Each beat carries a WIN x WIN pixel
//   window and produces an N x N (N = WIN-2) array of saturated signed Gx/Gy
//   using a per-beat kernel (0 Sobel, 1 Prewitt, 2 Scharr, 3 same as Sobel).
//   Ports:
//     clk    clock, all logic on posedge
//     reset  asynchronous active-low reset
//     bus    gradient_stream_if slave view (window in, gradients out)
//   Stage 1 registers the horizontal and vertical pixel differences plus the
//   mode; stage 2 weights, sums, clamps and registers the output beat.
module gradient_stream #(
    parameter int WIN   = 6,
    parameter int PIX_W = 8,
    parameter int OUT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    gradient_stream_if.slave  bus
);
    localparam int N     = WIN - 2;
    localparam int D_W   = PIX_W + 1;
    localparam int ACC_W = PIX_W + 6;
    // Comparison width wide enough to hold both the raw sum and the clamp bounds.
    localparam int CMP_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CMP_W-1:0] SAT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Flow control
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_adv, s2_adv, s1_load, s2_load;

    // Stage 1: dcol(r,c) = P(r,c+2) - P(r,c), drow(r,c) = P(r+2,c) - P(r,c)
    logic [1:0]            s1_mode_q, s1_mode_d;
    logic signed [D_W-1:0] dcol_q [WIN][N];
    logic signed [D_W-1:0] dcol_d [WIN][N];
    logic signed [D_W-1:0] drow_q [N][WIN];
    logic signed [D_W-1:0] drow_d [N][WIN];

    // Stage 2: output registers
    logic [N*N*OUT_W-1:0] gx_q, gx_d;
    logic [N*N*OUT_W-1:0] gy_q, gy_d;
    logic                 sat_q, sat_d;
    logic [OUT_W:0]       cx, cy;

    function automatic logic signed [D_W-1:0] pix_diff(input logic [PIX_W-1:0] hi,
                                                       input logic [PIX_W-1:0] lo);
        return $signed({1'b0, hi}) - $signed({1'b0, lo});
    endfunction

    // Weighted sum a*d0 + b*d1 + a*d2; full precision so it never overflows.
    function automatic logic signed [ACC_W-1:0] wsum(input logic [1:0]            m,
                                                     input logic signed [D_W-1:0] d0,
                                                     input logic signed [D_W-1:0] d1,
                                                     input logic signed [D_W-1:0] d2);
        logic signed [ACC_W-1:0] a;
        logic signed [ACC_W-1:0] b;
        case (m)
            2'd1:    begin a = ACC_W'(1); b = ACC_W'(1);  end
            2'd2:    begin a = ACC_W'(3); b = ACC_W'(10); end
            default: begin a = ACC_W'(1); b = ACC_W'(2);  end
        endcase
        return a * ACC_W'(d0) + b * ACC_W'(d1) + a * ACC_W'(d2);
    endfunction

    // Returns {clamped_flag, value[OUT_W-1:0]}.
    function automatic logic [OUT_W:0] clamp(input logic signed [ACC_W-1:0] v);
        logic signed [CMP_W-1:0] e;
        e = CMP_W'(v);
        if (e > SAT_MAX)
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        else if (e < SAT_MIN)
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        else
            return {1'b0, e[OUT_W-1:0]};
    endfunction

    // in_ready is combinational from out_ready through s2_adv, so a full
    // pipeline still accepts a beat in the same cycle one leaves.
    assign s2_adv  = !s2_valid_q || bus.out_ready;
    assign s1_adv  = !s1_valid_q || s2_adv;
    assign s1_load = bus.in_valid && s1_adv;
    assign s2_load = s1_valid_q && s2_adv;

    assign bus.in_ready  = s1_adv;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_gx    = gx_q;
    assign bus.out_gy    = gy_q;
    assign bus.out_sat   = sat_q;

    always_comb begin
        s1_valid_d = s1_adv ? bus.in_valid : s1_valid_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s1_mode_d  = bus.in_mode;
    end

    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            for (int c = 0; c < N; c++) begin
                dcol_d[r][c] = pix_diff(bus.in_window[(r*WIN+c+2)*PIX_W +: PIX_W],
                                        bus.in_window[(r*WIN+c)*PIX_W +: PIX_W]);
            end
        end
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < WIN; c++) begin
                drow_d[r][c] = pix_diff(bus.in_window[((r+2)*WIN+c)*PIX_W +: PIX_W],
                                        bus.in_window[(r*WIN+c)*PIX_W +: PIX_W]);
            end
        end
    end

    always_comb begin
        gx_d  = '0;
        gy_d  = '0;
        sat_d = 1'b0;
        cx    = '0;
        cy    = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                cx = clamp(wsum(s1_mode_q, dcol_q[r][c], dcol_q[r+1][c], dcol_q[r+2][c]));
                cy = clamp(wsum(s1_mode_q, drow_q[r][c], drow_q[r][c+1], drow_q[r][c+2]));
                gx_d[(r*N+c)*OUT_W +: OUT_W] = cx[OUT_W-1:0];
                gy_d[(r*N+c)*OUT_W +: OUT_W] = cy[OUT_W-1:0];
                sat_d = sat_d | cx[OUT_W] | cy[OUT_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= 2'd0;
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < N; c++)
                    dcol_q[r][c] <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < WIN; c++)
                    drow_q[r][c] <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (s1_load) begin
                s1_mode_q <= s1_mode_d;
                dcol_q    <= dcol_d;
                drow_q    <= drow_d;
            end
        end
    end

    // Output registers only move when a new beat enters stage 2, which keeps
    // them stable while the downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            gx_q       <= '0;
            gy_q       <= '0;
            sat_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s2_load) begin
                gx_q  <= gx_d;
                gy_q  <= gy_d;
                sat_q <= sat_d;
            end
        end
    end
endmodule

// File: tb/tb_gradient_stream.sv
// tb_gradient_stream
//   Drives two gradient_stream instances (OUT_W 16 and 10) with identical
//   stimulus; a scoreboard of bench-computed expected beats is filled on
//   input acceptance and compared on each output transfer.
module tb_gradient_stream;
    localparam int WIN = 6;
    localparam int N   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    gradient_stream_if #(.WIN(WIN), .PIX_W(8), .OUT_W(16)) b16 ();
    gradient_stream_if #(.WIN(WIN), .PIX_W(8), .OUT_W(10)) b10 ();

    gradient_stream #(.WIN(WIN), .PIX_W(8), .OUT_W(16)) dut16 (
        .clk(clk), .reset(reset), .bus(b16.slave));
    gradient_stream #(.WIN(WIN), .PIX_W(8), .OUT_W(10)) dut10 (
        .clk(clk), .reset(reset), .bus(b10.slave));

    typedef struct {
        logic [N*N*16-1:0] gx16;
        logic [N*N*16-1:0] gy16;
        logic              sat16;
        logic [N*N*10-1:0] gx10;
        logic [N*N*10-1:0] gy10;
        logic              sat10;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    int         pw[WIN][WIN];
    logic [1:0] cur_mode;
    bit         last_acc;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gval(input int p[WIN][WIN], input logic [1:0] m,
                                input int r, input int c, input bit isx);
        int a, b;
        a = 1; b = 2;
        if (m == 2'd1) begin a = 1; b = 1; end
        else if (m == 2'd2) begin a = 3; b = 10; end
        if (isx)
            return a*(p[r][c+2]-p[r][c]) + b*(p[r+1][c+2]-p[r+1][c]) + a*(p[r+2][c+2]-p[r+2][c]);
        return a*(p[r+2][c]-p[r][c]) + b*(p[r+2][c+1]-p[r][c+1]) + a*(p[r+2][c+2]-p[r][c+2]);
    endfunction

    function automatic int clampv(input int v, input int w);
        int hi, lo;
        hi = (1 << (w-1)) - 1;
        lo = -(1 << (w-1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic exp_t model(input int p[WIN][WIN], input logic [1:0] m);
        exp_t e;
        int   v, cv;
        e.gx16 = '0; e.gy16 = '0; e.sat16 = 1'b0;
        e.gx10 = '0; e.gy10 = '0; e.sat10 = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                v  = gval(p, m, r, c, 1'b1);
                cv = clampv(v, 16); if (cv != v) e.sat16 = 1'b1;
                e.gx16[(r*N+c)*16 +: 16] = 16'(cv);
                cv = clampv(v, 10); if (cv != v) e.sat10 = 1'b1;
                e.gx10[(r*N+c)*10 +: 10] = 10'(cv);
                v  = gval(p, m, r, c, 1'b0);
                cv = clampv(v, 16); if (cv != v) e.sat16 = 1'b1;
                e.gy16[(r*N+c)*16 +: 16] = 16'(cv);
                cv = clampv(v, 10); if (cv != v) e.sat10 = 1'b1;
                e.gy10[(r*N+c)*10 +: 10] = 10'(cv);
            end
        end
        return e;
    endfunction

    task automatic set_in(input bit v);
        logic [WIN*WIN*8-1:0] w;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                w[(r*WIN+c)*8 +: 8] = 8'(pw[r][c]);
        b16.in_window = w;       b10.in_window = w;
        b16.in_mode   = cur_mode; b10.in_mode  = cur_mode;
        b16.in_valid  = v;       b10.in_valid  = v;
    endtask

    task automatic set_ready(input bit r);
        b16.out_ready = r;
        b10.out_ready = r;
    endtask

    task automatic load_beat(input int k);
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                pw[r][c] = (k*37 + r*53 + c*29) & 255;
        cur_mode = 2'(k);
    endtask

    // Called just after a negedge with inputs already driven; samples both
    // handshakes before the coming posedge and returns at the next negedge.
    task automatic cycle();
        exp_t e;
        #1;
        last_acc = 1'b0;
        if (b16.out_valid && b16.out_ready) begin
            check("sb_has_entry", 256'(sb.size() > 0), 256'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("gx16",  b16.out_gx,  e.gx16);
                check("gy16",  b16.out_gy,  e.gy16);
                check("sat16", b16.out_sat, e.sat16);
                check("gx10",  b10.out_gx,  e.gx10);
                check("gy10",  b10.out_gy,  e.gy10);
                check("sat10", b10.out_sat, e.sat10);
            end
        end
        if (b16.in_valid && b16.in_ready) begin
            sb.push_back(model(pw, cur_mode));
            last_acc = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
        check("drain_empty", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                pw[r][c] = 0;
        cur_mode = 2'd0;
        set_ready(1'b1);
        set_in(1'b0);

        // Reset state
        #2;
        check("rst_out_valid", b16.out_valid, 0);
        check("rst_gx",        b16.out_gx, 0);
        check("rst_gy10",      b10.out_gy, 0);
        check("rst_sat",       b16.out_sat, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", b16.in_ready, 1);

        // Ramp, Sobel: Gx 80 everywhere, latency one edge after the accepting edge
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                pw[r][c] = 10*c;
        cur_mode = 2'd0;
        set_in(1'b1);
        cycle();
        check("t1_accept", last_acc, 1);
        set_in(1'b0);
        check("t1_not_yet", b16.out_valid, 0);
        cycle();
        check("t1_valid", b16.out_valid, 1);
        check("t1_gx00", b16.out_gx[15:0], 16'd80);
        drain();

        // Ramp in Prewitt then Scharr back to back
        cur_mode = 2'd1; set_in(1'b1); cycle();
        cur_mode = 2'd2; set_in(1'b1); cycle();
        set_in(1'b0);
        check("t2_a_valid", b16.out_valid, 1);
        check("t2_a_gx", b16.out_gx[15:0], 16'd60);
        cycle();
        check("t2_b_valid", b16.out_valid, 1);
        check("t2_b_gx", b16.out_gx[15:0], 16'd320);
        drain();

        // Vertical step in modes 0, 3, 2, then the negated step in mode 2
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                pw[r][c] = (r < 3) ? 0 : 255;
        cur_mode = 2'd0; set_in(1'b1); cycle();
        cur_mode = 2'd3; set_in(1'b1); cycle();
        cur_mode = 2'd2; set_in(1'b1); cycle();
        for (int r = 0; r < WIN; r++)
            for (int c = 0; c < WIN; c++)
                pw[r][c] = (r < 3) ? 255 : 0;
        set_in(1'b1); cycle();
        set_in(1'b0);
        drain();

        // Stall: only two beats fit, output held until released
        set_ready(1'b0);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            if (idx < 4) begin load_beat(idx); set_in(1'b1); end
            cycle();
            if (last_acc) idx++;
            if (b16.out_valid && sb.size() > 0)
                check("t5_hold_gx", b16.out_gx, sb[0].gx16);
        end
        check("t5_accepted", idx, 2);
        check("t5_in_ready", b16.in_ready, 0);
        set_ready(1'b1);
        for (int i = 0; i < 20 && idx < 4; i++) begin
            load_beat(idx); set_in(1'b1);
            cycle();
            if (last_acc) idx++;
        end
        check("t5_all_sent", idx, 4);
        set_in(1'b0);
        drain();

        // Random traffic with random back-pressure and extreme pixels
        for (int i = 0; i < 60; i++) begin
            for (int r = 0; r < WIN; r++)
                for (int c = 0; c < WIN; c++)
                    pw[r][c] = ($urandom_range(0, 2) == 0) ?
                               (($urandom_range(0, 1) == 1) ? 255 : 0) : int'($urandom_range(0, 255));
            cur_mode = 2'($urandom_range(0, 3));
            set_ready(1'($urandom_range(0, 3) != 0));
            set_in(1'($urandom_range(0, 3) != 0));
            cycle();
        end
        set_in(1'b0);
        set_ready(1'b1);
        drain();

        // Reset with two beats in flight
        set_ready(1'b0);
        idx = 0;
        for (int i = 0; i < 6 && idx < 2; i++) begin
            load_beat(idx + 5); set_in(1'b1);
            cycle();
            if (last_acc) idx++;
        end
        check("t6_loaded", idx, 2);
        set_in(1'b0);
        #2 reset = 1'b0;
        #1;
        check("t6_valid",  b16.out_valid, 0);
        check("t6_gx",     b16.out_gx, 0);
        check("t6_sat10",  b10.out_sat, 0);
        check("t6_ready",  b16.in_ready, 1);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        set_ready(1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t6_no_stale", b16.out_valid, 0);
        end
        load_beat(9); set_in(1'b1); cycle();
        set_in(1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
